// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode codes and the
// 32-bit rotate helper used by the rotated-immediate form of mode 00.
package imm_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_IMM8  = 2'b00;
    localparam imm_mode_t MODE_BR24  = 2'b01;
    localparam imm_mode_t MODE_IMM12 = 2'b10;
    localparam imm_mode_t MODE_RSVD  = 2'b11;

    function automatic logic [31:0] ror32(input logic [31:0] data, input logic [4:0] amt);
        logic [63:0] w_dbl;
        w_dbl = {data, data} >> amt;
        return w_dbl[31:0];
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus between decode, the immediate-extension pipeline and the ALU.
// master = producer/consumer side (decode + execute), slave = the pipeline itself.
import imm_pkg::*;

interface imm_extend_pipe_if #(
    parameter int IN_W   = 24,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    imm_mode_t         in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/imm_extend_pipe_core.sv
// Combinational mode decode and extension, fed from the stage-1 registers.
// Define IMM_ROTATE_EN to make mode 00 the ARM rotated immediate (needs DATA_W == 32).
import imm_pkg::*;

module imm_extend_core #(
    parameter int DATA_W       = 32,
    parameter int IN_W         = 24,
    parameter int BR_SHIFT     = 2,
    parameter bit IMM12_SIGNED = 1'b1
) (
    input  logic [IN_W-1:0]   i_data,
    input  imm_mode_t         i_mode,
    output logic [DATA_W-1:0] o_operand,
    output logic              o_err
);
    logic [DATA_W-1:0] w_imm8;
    logic [DATA_W-1:0] w_br_ext;
    logic [DATA_W-1:0] w_br;
    logic              w_imm12_fill;
    logic [DATA_W-1:0] w_imm12;

`ifdef IMM_ROTATE_EN
    logic [31:0] w_rot;
    // Rotate amount is twice the 4-bit field, i.e. always even.
    assign w_rot  = ror32({24'd0, i_data[7:0]}, {i_data[11:8], 1'b0});
    assign w_imm8 = DATA_W'(w_rot);

    generate
        if (DATA_W != 32) begin : g_width_chk
            $error("imm_extend_core: IMM_ROTATE_EN requires DATA_W == 32");
        end
    endgenerate
`else
    assign w_imm8 = {{(DATA_W-8){i_data[7]}}, i_data[7:0]};
`endif

    assign w_br_ext     = {{(DATA_W-IN_W){i_data[IN_W-1]}}, i_data};
    assign w_br         = w_br_ext << BR_SHIFT;
    assign w_imm12_fill = IMM12_SIGNED ? i_data[11] : 1'b0;
    assign w_imm12      = {{(DATA_W-12){w_imm12_fill}}, i_data[11:0]};

    // Select the extended operand for the requested mode.
    always_comb begin
        o_operand = '0;
        o_err     = 1'b0;
        case (i_mode)
            MODE_IMM8:  o_operand = w_imm8;
            MODE_BR24:  o_operand = w_br;
            MODE_IMM12: o_operand = w_imm12;
            MODE_RSVD: begin
                o_operand = '0;
                o_err     = 1'b1;
            end
            default: begin
                o_operand = '0;
                o_err     = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate-extension pipeline with independent valid/ready on both sides.
// Optional build macro: IMM_ROTATE_EN (rotated imm8 in mode 00).
import imm_pkg::*;

module imm_extend_pipe #(
    parameter int DATA_W       = 32,
    parameter int IN_W         = 24,
    parameter int BR_SHIFT     = 2,
    parameter bit IMM12_SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    imm_extend_pipe_if.slave    bus
);
    logic              r_s1_valid;
    logic [IN_W-1:0]   r_s1_data;
    imm_mode_t         r_s1_mode;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_err;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic [DATA_W-1:0] w_operand;
    logic              w_err;

    // A stage may load when empty or when the stage downstream is moving.
    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_err   = r_s2_err;

    imm_extend_core #(
        .DATA_W       (DATA_W),
        .IN_W         (IN_W),
        .BR_SHIFT     (BR_SHIFT),
        .IMM12_SIGNED (IMM12_SIGNED)
    ) u_core (
        .i_data    (r_s1_data),
        .i_mode    (r_s1_mode),
        .o_operand (w_operand),
        .o_err     (w_err)
    );

    // Stage registers; payload only loads alongside a valid item.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= MODE_IMM8;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_data <= bus.in_data;
                    r_s1_mode <= bus.in_mode;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_operand;
                    r_s2_err  <= w_err;
                end
            end
        end
    end
endmodule
